// File: rtl/hog_image_bank_loader_if.sv
// Pixel stream handshake between a raster-order pixel source and the bank loader.
//   s_pix_valid : source has a pixel on s_pix_data
//   s_pix_data  : pixel value, P_WIDTH bits
//   s_pix_ready : loader accepts the pixel this cycle (valid & ready)
// master = pixel source, slave = loader.
interface hog_image_bank_loader_if #(
    parameter int unsigned P_WIDTH = 8
) ();
    logic               s_pix_valid;
    logic [P_WIDTH-1:0] s_pix_data;
    logic               s_pix_ready;

    modport master (
        output s_pix_valid,
        output s_pix_data,
        input  s_pix_ready
    );

    modport slave (
        input  s_pix_valid,
        input  s_pix_data,
        output s_pix_ready
    );
endinterface

// File: rtl/hog_image_bank_loader.sv
// Loads one raster-order image frame into four interleaved RAM banks. Pixel (r, c) goes to
// bank {r[0], c[0]} at address (r>>1)*ceil(width/2) + (c>>1), so each bank holds one phase of
// a 2x2 polyphase split. A one-cycle start pulse follows the final write.
//
// Ports:
//   aclk, arest_n          clock, synchronous active-low reset
//   load_req               pulse; starts a frame load when idle
//   cfg_width, cfg_height  frame dimensions, sampled on an accepted load_req
//   pix                    pixel stream (slave side of hog_image_bank_loader_if)
//   initial_{wea,ena}_k    bank k write strobe/enable (registered, one cycle per write)
//   initial_addra_k        bank k write address (holds when bank not written)
//   initial_dina_k         bank k write data (holds when bank not written)
//   row_signal             number of fully written rows of the current frame
//   start                  one-cycle pulse the cycle after the final write strobe
//   busy                   high while pixels are being accepted
//   cfg_err                sticky flag: a load_req with illegal dimensions was rejected
module hog_image_bank_loader #(
    parameter int unsigned RAM_AW  = 17,
    parameter int unsigned P_WIDTH = 8,
    parameter int unsigned MAX_DIM = 136
) (
    input  logic                aclk,
    input  logic                arest_n,
    input  logic                load_req,
    input  logic [15:0]         cfg_width,
    input  logic [15:0]         cfg_height,
    hog_image_bank_loader_if.slave pix,
    output logic                initial_wea_0,
    output logic                initial_wea_1,
    output logic                initial_wea_2,
    output logic                initial_wea_3,
    output logic                initial_ena_0,
    output logic                initial_ena_1,
    output logic                initial_ena_2,
    output logic                initial_ena_3,
    output logic [RAM_AW-1:0]   initial_addra_0,
    output logic [RAM_AW-1:0]   initial_addra_1,
    output logic [RAM_AW-1:0]   initial_addra_2,
    output logic [RAM_AW-1:0]   initial_addra_3,
    output logic [P_WIDTH-1:0]  initial_dina_0,
    output logic [P_WIDTH-1:0]  initial_dina_1,
    output logic [P_WIDTH-1:0]  initial_dina_2,
    output logic [P_WIDTH-1:0]  initial_dina_3,
    output logic [31:0]         row_signal,
    output logic                start,
    output logic                busy,
    output logic                cfg_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StFin} state_e;

    state_e              state_q, state_d;
    logic [15:0]         width_q, width_d;
    logic [15:0]         height_q, height_d;
    logic [RAM_AW-1:0]   hw_q, hw_d;            // half width, rounded up
    logic [15:0]         col_q, col_d;
    logic [15:0]         row_q, row_d;
    logic [RAM_AW-1:0]   row_base_q, row_base_d; // (row>>1) * hw, accumulated per row pair
    logic [31:0]         row_cnt_q, row_cnt_d;
    logic [3:0]          wea_q, wea_d;
    logic [RAM_AW-1:0]   addr_q [4];
    logic [RAM_AW-1:0]   addr_d [4];
    logic [P_WIDTH-1:0]  din_q [4];
    logic [P_WIDTH-1:0]  din_d [4];
    logic                start_q, start_d;
    logic                err_q, err_d;

    logic        accept;
    logic        cfg_legal;
    logic [1:0]  bank;
    logic [16:0] width_p1;

    assign accept    = pix.s_pix_valid && (state_q == StLoad);
    assign bank      = {row_q[0], col_q[0]};
    assign width_p1  = {1'b0, cfg_width} + 17'd1;
    assign cfg_legal = (cfg_width != 16'd0) && (cfg_height != 16'd0) &&
                       ({16'd0, cfg_width} <= MAX_DIM) && ({16'd0, cfg_height} <= MAX_DIM);

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        hw_d       = hw_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        row_cnt_d  = row_cnt_q;
        wea_d      = 4'b0000;
        addr_d     = addr_q;
        din_d      = din_q;
        start_d    = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (load_req) begin
                    if (cfg_legal) begin
                        width_d    = cfg_width;
                        height_d   = cfg_height;
                        hw_d       = RAM_AW'(width_p1[16:1]);
                        col_d      = 16'd0;
                        row_d      = 16'd0;
                        row_base_d = '0;
                        row_cnt_d  = 32'd0;
                        state_d    = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    wea_d[bank]  = 1'b1;
                    addr_d[bank] = row_base_q + RAM_AW'(col_q >> 1);
                    din_d[bank]  = pix.s_pix_data;
                    if (col_q == width_q - 16'd1) begin
                        col_d     = 16'd0;
                        row_d     = row_q + 16'd1;
                        // Counted on the same edge that registers the row's last strobe.
                        row_cnt_d = row_cnt_q + 32'd1;
                        // Leaving an odd row starts the next row pair in the banks.
                        if (row_q[0]) begin
                            row_base_d = row_base_q + hw_q;
                        end
                        if (row_q == height_q - 16'd1) begin
                            state_d = StFin;
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            StFin: begin
                // The final strobe is visible during this cycle; start follows it.
                start_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arest_n) begin
            state_q    <= StIdle;
            width_q    <= 16'd0;
            height_q   <= 16'd0;
            hw_q       <= '0;
            col_q      <= 16'd0;
            row_q      <= 16'd0;
            row_base_q <= '0;
            row_cnt_q  <= 32'd0;
            wea_q      <= 4'b0000;
            addr_q     <= '{default: '0};
            din_q      <= '{default: '0};
            start_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            hw_q       <= hw_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            row_cnt_q  <= row_cnt_d;
            wea_q      <= wea_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            start_q    <= start_d;
            err_q      <= err_d;
        end
    end

    assign pix.s_pix_ready = (state_q == StLoad);
    assign busy            = (state_q == StLoad);
    assign start           = start_q;
    assign cfg_err         = err_q;
    assign row_signal      = row_cnt_q;

    assign initial_wea_0   = wea_q[0];
    assign initial_wea_1   = wea_q[1];
    assign initial_wea_2   = wea_q[2];
    assign initial_wea_3   = wea_q[3];
    assign initial_ena_0   = wea_q[0];
    assign initial_ena_1   = wea_q[1];
    assign initial_ena_2   = wea_q[2];
    assign initial_ena_3   = wea_q[3];
    assign initial_addra_0 = addr_q[0];
    assign initial_addra_1 = addr_q[1];
    assign initial_addra_2 = addr_q[2];
    assign initial_addra_3 = addr_q[3];
    assign initial_dina_0  = din_q[0];
    assign initial_dina_1  = din_q[1];
    assign initial_dina_2  = din_q[2];
    assign initial_dina_3  = din_q[3];

endmodule

// File: tb/tb_hog_image_bank_loader.sv
// Self-checking bench for hog_image_bank_loader: randomized pixel gaps and data, checked every
// cycle against a frame-level model (pixel index -> bank/address arithmetic), plus directed
// spot checks of known bank contents.
module tb_hog_image_bank_loader;

    logic        aclk = 1'b0;
    logic        arest_n = 1'b0;
    logic        load_req = 1'b0;
    logic [15:0] cfg_width = 16'd0;
    logic [15:0] cfg_height = 16'd0;

    logic        wea0, wea1, wea2, wea3, ena0, ena1, ena2, ena3;
    logic [16:0] addr0, addr1, addr2, addr3;
    logic [7:0]  din0, din1, din2, din3;
    logic [31:0] row_signal;
    logic        start, busy, cfg_err;

    hog_image_bank_loader_if #(.P_WIDTH(8)) pix ();

    hog_image_bank_loader #(
        .RAM_AW (17),
        .P_WIDTH(8),
        .MAX_DIM(136)
    ) dut (
        .aclk           (aclk),
        .arest_n        (arest_n),
        .load_req       (load_req),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .pix            (pix.slave),
        .initial_wea_0  (wea0),
        .initial_wea_1  (wea1),
        .initial_wea_2  (wea2),
        .initial_wea_3  (wea3),
        .initial_ena_0  (ena0),
        .initial_ena_1  (ena1),
        .initial_ena_2  (ena2),
        .initial_ena_3  (ena3),
        .initial_addra_0(addr0),
        .initial_addra_1(addr1),
        .initial_addra_2(addr2),
        .initial_addra_3(addr3),
        .initial_dina_0 (din0),
        .initial_dina_1 (din1),
        .initial_dina_2 (din2),
        .initial_dina_3 (din3),
        .row_signal     (row_signal),
        .start          (start),
        .busy           (busy),
        .cfg_err        (cfg_err)
    );

    initial forever #5 aclk = ~aclk;

    // Reference model: frame phase 0 = idle, 1 = accepting pixels, 2 = last write issued.
    int          phase = 0;
    int          lw = 0, lh = 0, mr = 0, mc = 0;
    logic [31:0] m_rows = 32'd0;
    logic        m_err = 1'b0;
    logic [16:0] m_addr [4] = '{default: '0};
    logic [7:0]  m_din [4] = '{default: '0};
    bit          last_acc = 1'b0;

    // Observations collected from the DUT outputs.
    int          strobes = 0, starts = 0, max_addr = 0;
    logic [7:0]  obs_mem [4][4700];

    int          n_checks = 0, n_err = 0;

    task automatic check(input string tag, input logic [143:0] o, input logic [143:0] e);
        n_checks++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [143:0] obs_vec();
        return {wea3, wea2, wea1, wea0, ena3, ena2, ena1, ena0,
                addr3, addr2, addr1, addr0, din3, din2, din1, din0,
                row_signal, start, busy, pix.s_pix_ready, cfg_err};
    endfunction

    // One clock: advance the model with the current inputs, clock the DUT, compare everything.
    task automatic cycle();
        logic [3:0]  ew;
        logic        st_exp;
        logic        act;
        logic [16:0] a [4];
        logic [7:0]  d [4];
        logic        w [4];
        int          b;
        ew = 4'b0000;
        st_exp = 1'b0;
        last_acc = 1'b0;
        if (!arest_n) begin
            phase = 0; mr = 0; mc = 0; m_rows = 32'd0; m_err = 1'b0;
            m_addr = '{default: '0};
            m_din  = '{default: '0};
        end else begin
            case (phase)
                0: if (load_req) begin
                    if (cfg_width >= 1 && cfg_width <= 136 && cfg_height >= 1 &&
                        cfg_height <= 136) begin
                        phase = 1; lw = int'(cfg_width); lh = int'(cfg_height);
                        mr = 0; mc = 0; m_rows = 32'd0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                1: if (pix.s_pix_valid) begin
                    b = 2 * (mr % 2) + (mc % 2);
                    ew[b] = 1'b1;
                    m_addr[b] = 17'((mr / 2) * ((lw + 1) / 2) + mc / 2);
                    m_din[b] = pix.s_pix_data;
                    last_acc = 1'b1;
                    if (mc == lw - 1) begin
                        mc = 0; mr++; m_rows++;
                        if (mr == lh) phase = 2;
                    end else begin
                        mc++;
                    end
                end
                default: begin
                    phase = 0; st_exp = 1'b1;
                end
            endcase
        end
        act = (phase == 1);
        @(posedge aclk);
        #1;
        check("outputs", obs_vec(), {ew, ew, m_addr[3], m_addr[2], m_addr[1], m_addr[0],
              m_din[3], m_din[2], m_din[1], m_din[0], m_rows, st_exp, act, act, m_err});
        a = '{addr0, addr1, addr2, addr3};
        d = '{din0, din1, din2, din3};
        w = '{wea0, wea1, wea2, wea3};
        for (int k = 0; k < 4; k++) begin
            if (w[k] === 1'b1) begin
                strobes++;
                if (int'(a[k]) > max_addr) max_addr = int'(a[k]);
                if (a[k] < 17'd4700) obs_mem[k][a[k]] = d[k];
            end
        end
        if (start === 1'b1) starts++;
    endtask

    task automatic do_reset();
        arest_n = 1'b0;
        pix.s_pix_valid = 1'b0;
        cycle();
        arest_n = 1'b1;
    endtask

    // Issue load_req for a w x h frame and stream its pixels. Pixel data is the raster index when
    // seq is set. rst_after aborts with a reset before that pixel; req_at pulses a second
    // load_req with other dimensions while that pixel is being offered.
    task automatic run_frame(input int w, input int h, input int gap, input int rst_after,
                             input int req_at, input bit seq);
        int tries;
        strobes = 0; starts = 0; max_addr = 0;
        load_req = 1'b1; cfg_width = 16'(w); cfg_height = 16'(h);
        pix.s_pix_valid = 1'b0;
        cycle();
        load_req = 1'b0;
        for (int i = 0; i < w * h; i++) begin
            if (i == rst_after) begin
                do_reset();
                return;
            end
            tries = 0;
            do begin
                pix.s_pix_valid = ($urandom_range(99) >= gap);
                pix.s_pix_data = seq ? 8'(i) : 8'($urandom);
                if (i == req_at) begin
                    load_req = 1'b1; cfg_width = 16'd5; cfg_height = 16'd3;
                end
                cycle();
                load_req = 1'b0; cfg_width = 16'(w); cfg_height = 16'(h);
                tries++;
            end while (!last_acc && tries < 500);
            if (!last_acc) begin
                n_checks++; n_err++;
                $error("FAIL pixel_timeout: pixel %0d never accepted, required acceptance", i);
                return;
            end
        end
        pix.s_pix_valid = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        check(tag, 144'(o), 144'(e));
    endtask

    initial begin
        pix.s_pix_valid = 1'b0;
        pix.s_pix_data = 8'd0;
        do_reset();
        cycle();

        // 4x4, data = raster index, no gaps.
        run_frame(4, 4, 0, -1, -1, 1'b1);
        check_int("4x4 strobes", strobes, 16);
        check_int("4x4 starts", starts, 1);
        check_int("4x4 b0a0", int'(obs_mem[0][0]), 0);
        check_int("4x4 b1a0", int'(obs_mem[1][0]), 1);
        check_int("4x4 b2a0", int'(obs_mem[2][0]), 4);
        check_int("4x4 b3a0", int'(obs_mem[3][0]), 5);
        check_int("4x4 b0a3", int'(obs_mem[0][3]), 10);
        check_int("4x4 b3a3", int'(obs_mem[3][3]), 15);

        // 3x3, odd dimensions leave slots unwritten.
        run_frame(3, 3, 0, -1, -1, 1'b1);
        check_int("3x3 strobes", strobes, 9);
        check_int("3x3 b0a1", int'(obs_mem[0][1]), 2);
        check_int("3x3 b0a2", int'(obs_mem[0][2]), 6);
        check_int("3x3 b0a3", int'(obs_mem[0][3]), 8);
        check_int("3x3 b1a2", int'(obs_mem[1][2]), 7);
        check_int("3x3 b2a1", int'(obs_mem[2][1]), 5);
        check_int("3x3 b3a0", int'(obs_mem[3][0]), 4);

        // Illegal dimensions: rejected, sticky error, no writes even with valid pixels.
        strobes = 0; starts = 0;
        load_req = 1'b1; cfg_width = 16'd0; cfg_height = 16'd4; cycle();
        load_req = 1'b0; pix.s_pix_valid = 1'b1; repeat (3) cycle();
        load_req = 1'b1; cfg_width = 16'd137; cfg_height = 16'd4; cycle();
        load_req = 1'b1; cfg_width = 16'd4; cfg_height = 16'd0; cycle();
        load_req = 1'b0; repeat (3) cycle();
        pix.s_pix_valid = 1'b0;
        check_int("illegal strobes", strobes, 0);
        check_int("illegal starts", starts, 0);

        // Reset after 7 pixels, valid alone must not resume, then a full fresh frame.
        run_frame(4, 4, 0, 7, -1, 1'b1);
        pix.s_pix_valid = 1'b1;
        strobes = 0;
        repeat (4) cycle();
        pix.s_pix_valid = 1'b0;
        check_int("post-reset strobes", strobes, 0);
        run_frame(4, 4, 20, -1, -1, 1'b0);
        check_int("refill strobes", strobes, 16);

        // load_req mid-frame is ignored.
        run_frame(6, 5, 30, -1, 10, 1'b0);
        check_int("midreq strobes", strobes, 30);
        check_int("midreq starts", starts, 1);

        // Random dimensions including the 1x1 corner.
        run_frame(1, 1, 0, -1, -1, 1'b0);
        check_int("1x1 strobes", strobes, 1);
        for (int k = 0; k < 3; k++) begin
            int rw, rh;
            rw = int'($urandom_range(12, 1));
            rh = int'($urandom_range(12, 1));
            run_frame(rw, rh, 30, -1, -1, 1'b0);
            check_int("rand strobes", strobes, rw * rh);
        end

        // Maximum frame with random gaps.
        run_frame(136, 136, 25, -1, -1, 1'b0);
        check_int("max strobes", strobes, 18496);
        check_int("max addr", max_addr, 4623);
        check_int("max rows", int'(row_signal), 136);
        check_int("max starts", starts, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hog_image_bank_loader.md
HOG_IMAGE_BANK_LOADER -- requirements
Module: hog_image_bank_loader

Interface
REQ-001 SHALL have parameter RAM_AW, default 17: bank address width.
REQ-002 SHALL have parameter P_WIDTH, default 8: pixel width.
REQ-003 SHALL have parameter MAX_DIM, default 136: maximum accepted width/height.
REQ-004 SHALL use one clock; reset is synchronous and active-low. Ports: aclk input 1, clock; arest_n input 1, synchronous active-low reset.
REQ-005 SHALL have port load_req input 1: pulse, start a frame load.
REQ-006 SHALL have port cfg_width input 16: image columns, sampled on accepted load_req.
REQ-007 SHALL have port cfg_height input 16: image rows, sampled on accepted load_req.
REQ-008 SHALL have port s_pix_valid input 1: raster-order pixel valid.
REQ-009 SHALL have port s_pix_data input P_WIDTH: pixel value.
REQ-010 SHALL have port s_pix_ready output 1: pixel accepted when valid&ready.
REQ-011 SHALL have ports initial_wea_k, initial_ena_k output 1 each, k=0..3: bank k write strobe/enable.
REQ-012 SHALL have port initial_addra_k output RAM_AW, k=0..3: bank k write address.
REQ-013 SHALL have port initial_dina_k output P_WIDTH, k=0..3: bank k write data.
REQ-014 SHALL have port row_signal output 32: count of fully written rows.
REQ-015 SHALL have port start output 1: one-cycle pulse to scaling stage after last write.
REQ-016 SHALL have port busy output 1: high in LOAD.
REQ-017 SHALL have port cfg_err output 1: sticky, illegal dimensions rejected.

Function
REQ-018 SHALL implement states IDLE, LOAD, FIN.
REQ-019 IDLE: s_pix_ready=0; on load_req with 1<=cfg_width,cfg_height<=MAX_DIM, latch dims, clear counters and row_signal, enter LOAD.
REQ-020 IDLE: load_req with zero or >MAX_DIM dimension SHALL set cfg_err, stay IDLE, issue no writes and no start.
REQ-021 LOAD: s_pix_ready=1; each accepted pixel at (row r, col c) SHALL go to bank b={r[0],c[0]} (b=2*r[0]+c[0]).
REQ-022 Bank address SHALL be (r>>1)*HW+(c>>1), HW=(width+1)>>1; computed with running row-base accumulator, no multiplier.
REQ-023 Write outputs SHALL be registered: initial_ena_b=initial_wea_b=1 exactly one cycle after acceptance, other banks 0 that cycle.
REQ-024 Data/address outputs of non-written banks SHALL hold previous value.
REQ-025 Column counter SHALL wrap to 0 at width-1 and increment row; row_signal SHALL increment in the same cycle the row's last write strobe asserts.
REQ-026 Acceptance of pixel (height-1,width-1) SHALL move to FIN; s_pix_ready SHALL drop the next cycle.
REQ-027 FIN: start=1 for exactly the cycle after the final write strobe, then IDLE.
REQ-028 load_req in LOAD or FIN SHALL be ignored; cfg_err not set.
REQ-029 Gaps in s_pix_valid SHALL stall counters with no writes.
REQ-030 Odd width/height SHALL leave unused bank slots unwritten; no padding writes.

Reset
REQ-031 arest_n=0 at any clock edge, including mid-LOAD, SHALL force IDLE, all wea/ena/start/busy/s_pix_ready=0, all addra/dina=0, row_signal=0, cfg_err=0, counters 0.
REQ-032 After reset, no partial frame SHALL resume; next frame requires new load_req.

Verification
REQ-033 4x4, pixels 0..15 continuous -> bank0 addr0=0, bank1 addr0=1, bank2 addr0=4, bank3 addr0=5, bank0 addr3=10, bank3 addr3=15; 16 strobes total; start one cycle after pixel 15's strobe.
REQ-034 3x3, pixels 0..8 -> HW=2; bank0 addr{0,1,2,3}={0,2,6,8}, bank1 addr{0,2}={1,7}, bank2 addr{0,1}={3,5}, bank3 addr0=4; row_signal 1,2,3 at strobes of pixels 2,5,8.
REQ-035 136x136 with random valid gaps -> 18496 strobes, max addr 4623 per bank, row_signal ends at 136, single start pulse.
REQ-036 cfg_width=0 or 137 -> cfg_err=1, no strobes, no start, busy=0.
REQ-037 Reset asserted after 7 pixels of 4x4 load -> next cycle all outputs 0, row_signal=0; fresh load_req loads full frame correctly.
REQ-038 load_req pulsed mid-LOAD with new dims -> ignored, original frame completes with original addressing.
